// File: rtl/input_arbiter_rr.sv
// Round-robin input arbiter: per-port 8-deep FIFOs merged into one packet stream.
// Whole packets are granted; the IOQ header source-port field is rewritten with the granted port.
module input_arbiter_rr #(
    parameter int unsigned DATA_WIDTH       = 64,
    parameter int unsigned CTRL_WIDTH       = DATA_WIDTH / 8,
    parameter int unsigned NUM_INPUT_QUEUES = 8
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [NUM_INPUT_QUEUES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_INPUT_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
    input  logic [NUM_INPUT_QUEUES-1:0]            in_wr,
    output logic [NUM_INPUT_QUEUES-1:0]            in_rdy,
    output logic [DATA_WIDTH-1:0]                  out_data,
    output logic [CTRL_WIDTH-1:0]                  out_ctrl,
    output logic                                   out_wr,
    input  logic                                   out_rdy
);
    localparam int unsigned QW         = (NUM_INPUT_QUEUES > 1) ? $clog2(NUM_INPUT_QUEUES) : 1;
    localparam int unsigned FW         = CTRL_WIDTH + DATA_WIDTH;
    localparam int unsigned DEPTH_BITS = 3;
    localparam int unsigned DEPTH      = 1 << DEPTH_BITS;
    localparam int unsigned CW         = DEPTH_BITS + 1;
    localparam int unsigned SRC_POS    = 16;
    localparam int unsigned SRC_W      = 16;
    localparam logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM = CTRL_WIDTH'(8'hFF);

    typedef enum logic [1:0] {S_SELECT, S_HDR, S_PAYLOAD} state_e;

    state_e                      state_q, state_d;
    logic [QW-1:0]               cur_q, cur_d;
    logic [QW-1:0]               rr_ptr_q, rr_ptr_d;
    logic                        eop_pending_q, eop_pending_d;
    logic                        out_wr_q, out_wr_d;
    logic [DATA_WIDTH-1:0]       out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0]       out_ctrl_q, out_ctrl_d;
    logic [NUM_INPUT_QUEUES-1:0] in_rdy_q, in_rdy_d;

    logic [FW-1:0]               fifo_mem_q [NUM_INPUT_QUEUES][DEPTH];
    logic [DEPTH_BITS-1:0]       wr_ptr_q   [NUM_INPUT_QUEUES];
    logic [DEPTH_BITS-1:0]       rd_ptr_q   [NUM_INPUT_QUEUES];
    logic [CW-1:0]               count_q    [NUM_INPUT_QUEUES];
    logic [CW-1:0]               count_d    [NUM_INPUT_QUEUES];
    logic [NUM_INPUT_QUEUES-1:0] empty, wr_en, rd_en;

    logic [FW-1:0]               head;
    logic [CTRL_WIDTH-1:0]       head_ctrl;
    logic [DATA_WIDTH-1:0]       head_data;
    logic                        rd_go;
    logic                        found;
    logic [QW-1:0]               idx;

    assign in_rdy   = in_rdy_q;
    assign out_wr   = out_wr_q;
    assign out_data = out_data_q;
    assign out_ctrl = out_ctrl_q;

    // A write into a full FIFO is dropped; the producer owns that violation.
    always_comb begin
        for (int i = 0; i < NUM_INPUT_QUEUES; i++) begin
            empty[i] = (count_q[i] == '0);
            wr_en[i] = in_wr[i] && (count_q[i] != CW'(DEPTH));
        end
    end

    assign head      = fifo_mem_q[cur_q][rd_ptr_q[cur_q]];
    assign head_ctrl = head[FW-1 -: CTRL_WIDTH];
    assign head_data = head[DATA_WIDTH-1:0];

    // Next-state: grant search in SELECT, packet drain in HDR/PAYLOAD.
    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        rr_ptr_d      = rr_ptr_q;
        eop_pending_d = eop_pending_q;
        rd_en         = '0;
        rd_go         = 1'b0;
        found         = 1'b0;
        idx           = '0;
        unique case (state_q)
            S_SELECT: begin
                for (int k = 0; k < NUM_INPUT_QUEUES; k++) begin
                    idx = QW'((32'(rr_ptr_q) + 32'(k)) % NUM_INPUT_QUEUES);
                    if (!found && !empty[idx]) begin
                        found   = 1'b1;
                        cur_d   = idx;
                        state_d = S_HDR;
                    end
                end
            end
            S_HDR, S_PAYLOAD: begin
                if (eop_pending_q) begin
                    eop_pending_d = 1'b0;
                    rr_ptr_d      = QW'((32'(cur_q) + 32'd1) % NUM_INPUT_QUEUES);
                    state_d       = S_SELECT;
                end else begin
                    rd_go        = !empty[cur_q] && out_rdy;
                    rd_en[cur_q] = rd_go;
                    if (rd_go) begin
                        if (state_q == S_HDR && head_ctrl == '0) begin
                            state_d = S_PAYLOAD;
                        end else if (state_q == S_PAYLOAD && head_ctrl != '0) begin
                            eop_pending_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_SELECT;
        endcase
    end

    // Output word: one-cycle registered copy of the word being read.
    always_comb begin
        out_wr_d   = rd_go;
        out_data_d = out_data_q;
        out_ctrl_d = out_ctrl_q;
        if (rd_go) begin
            out_ctrl_d = head_ctrl;
            out_data_d = head_data;
            if (state_q == S_HDR && head_ctrl == IOQ_STAGE_NUM) begin
                out_data_d[SRC_POS +: SRC_W] = SRC_W'(cur_q);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_INPUT_QUEUES; i++) begin
            count_d[i]  = count_q[i] + CW'(wr_en[i]) - CW'(rd_en[i]);
            in_rdy_d[i] = (count_d[i] < CW'(DEPTH - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_SELECT;
            cur_q         <= '0;
            rr_ptr_q      <= '0;
            eop_pending_q <= 1'b0;
            out_wr_q      <= 1'b0;
            out_data_q    <= '0;
            out_ctrl_q    <= '0;
            in_rdy_q      <= '1;
            for (int i = 0; i < NUM_INPUT_QUEUES; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            rr_ptr_q      <= rr_ptr_d;
            eop_pending_q <= eop_pending_d;
            out_wr_q      <= out_wr_d;
            out_data_q    <= out_data_d;
            out_ctrl_q    <= out_ctrl_d;
            in_rdy_q      <= in_rdy_d;
            for (int i = 0; i < NUM_INPUT_QUEUES; i++) begin
                count_q[i] <= count_d[i];
                if (wr_en[i]) wr_ptr_q[i] <= wr_ptr_q[i] + DEPTH_BITS'(1);
                if (rd_en[i]) rd_ptr_q[i] <= rd_ptr_q[i] + DEPTH_BITS'(1);
            end
        end
    end

    // FIFO storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_INPUT_QUEUES; i++) begin
            if (wr_en[i]) begin
                fifo_mem_q[i][wr_ptr_q[i]] <= {in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH],
                                               in_data[i*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

endmodule

// File: tb/tb_input_arbiter_rr.sv
// Directed bench for input_arbiter_rr: framing, round-robin order, stalls and reset.
module tb_input_arbiter_rr;
    localparam int unsigned DW  = 64;
    localparam int unsigned CWD = 8;
    localparam int unsigned NQ  = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NQ*DW-1:0]  in_data;
    logic [NQ*CWD-1:0] in_ctrl;
    logic [NQ-1:0]     in_wr;
    logic [NQ-1:0]     in_rdy;
    logic [DW-1:0]     out_data;
    logic [CWD-1:0]    out_ctrl;
    logic              out_wr;
    logic              out_rdy;

    always #5 clk = ~clk;

    input_arbiter_rr #(.DATA_WIDTH(DW), .CTRL_WIDTH(CWD), .NUM_INPUT_QUEUES(NQ)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
        .in_rdy(in_rdy), .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr),
        .out_rdy(out_rdy)
    );

    typedef struct { logic [7:0] c; logic [63:0] d; int cyc; } ow_t;
    ow_t got[$];
    int  cyc    = 0;
    int  passed = 0;
    int  fails  = 0;
    bit  tog    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (out_wr === 1'b1) got.push_back('{c: out_ctrl, d: out_data, cyc: cyc});

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mk(int p, int pk, int w);
        return {8'(p), 8'(pk), 8'(w), 8'h5A, 32'hDEAD_BEEF};
    endfunction

    function automatic logic [7:0] ctl(int w, int n);
        if (w == 0) return 8'hFF;
        if (w == n + 1) return 8'h01;
        return 8'h00;
    endfunction

    // Header src field [31:16] carries the granted port number.
    function automatic logic [71:0] exp_word(int p, int pk, int w, int n);
        logic [63:0] d;
        d = mk(p, pk, w);
        if (w == 0) d[31:16] = 16'(p);
        return {ctl(w, n), d};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        if (tog) out_rdy = ~out_rdy;
    endtask

    task automatic drive(input logic [NQ-1:0] mask, input int pk, input int w, input int n);
        for (int i = 0; i < NQ; i++) begin
            in_data[i*DW +: DW]   = mk(i, pk, w);
            in_ctrl[i*CWD +: CWD] = ctl(w, n);
        end
        in_wr = mask;
        tick();
        in_wr = '0;
    endtask

    task automatic wait_words(input string tag, input int n);
        int k;
        k = 0;
        while (got.size() < n && k < 200) begin
            tick();
            k++;
        end
        repeat (8) tick();
        chk(tag, got.size(), n);
    endtask

    // min_gap: 0 = no spacing check, 1 = back-to-back, 2 = at least one idle cycle.
    task automatic check_pkt(input string tag, input int base, input int p, input int pk,
                             input int n, input int min_gap);
        for (int w = 0; w <= n + 1; w++) begin
            int          idx;
            int          dcyc;
            logic [71:0] obs;
            idx = base + w;
            obs = {72{1'bx}};
            if (idx < got.size()) obs = {got[idx].c, got[idx].d};
            chk($sformatf("%s_w%0d", tag, w), obs, exp_word(p, pk, w, n));
            if (w > 0 && min_gap > 0 && idx < got.size()) begin
                dcyc = got[idx].cyc - got[idx-1].cyc;
                chk($sformatf("%s_spacing%0d", tag, w),
                    (min_gap == 1) ? (dcyc == 1) : (dcyc >= min_gap), 1);
            end
        end
    endtask

    task automatic gap_chk(input string tag, input int a);
        if (a < got.size()) chk(tag, (got[a].cyc - got[a-1].cyc) >= 2, 1);
        else chk(tag, got.size(), a + 1);
    endtask

    initial begin
        reset_n = 1'b0;
        in_wr   = '0;
        in_data = '0;
        in_ctrl = '0;
        out_rdy = 1'b1;
        repeat (3) tick();
        chk("rst_out_wr", out_wr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        reset_n = 1'b1;
        tick();
        chk("rst_in_rdy", in_rdy, 8'hFF);

        // Single IOQ-headed packet on port 3.
        got.delete();
        for (int w = 0; w < 6; w++) drive(8'h08, 1, w, 4);
        wait_words("p3_count", 6);
        check_pkt("p3", 0, 3, 1, 4, 1);

        // Ports 0, 2, 7 loaded together with rr_ptr at 0.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        got.delete();
        for (int w = 0; w < 5; w++) drive(8'h85, 2, w, 3);
        wait_words("rr_count", 15);
        check_pkt("rr_p0", 0, 0, 2, 3, 1);
        check_pkt("rr_p2", 5, 2, 2, 3, 1);
        check_pkt("rr_p7", 10, 7, 2, 3, 1);
        gap_chk("rr_gap02", 5);
        gap_chk("rr_gap27", 10);

        // Port 5 back-to-back with port 6 waiting: 5, 6, 5.
        got.delete();
        for (int w = 0; w < 4; w++) drive(8'h60, 3, w, 2);
        for (int w = 0; w < 4; w++) drive(8'h20, 4, w, 2);
        wait_words("fair_count", 12);
        check_pkt("fair_p5a", 0, 5, 3, 2, 1);
        check_pkt("fair_p6", 4, 6, 3, 2, 1);
        check_pkt("fair_p5b", 8, 5, 4, 2, 1);

        // out_rdy toggling during an 8-word packet on port 0.
        got.delete();
        tog = 1'b1;
        for (int w = 0; w < 8; w++) drive(8'h01, 5, w, 6);
        wait_words("bp_count", 8);
        tog     = 1'b0;
        out_rdy = 1'b1;
        check_pkt("bp", 0, 0, 5, 6, 2);

        // Port 1 pauses mid-payload while port 4 holds a full packet.
        got.delete();
        drive(8'h12, 6, 0, 3);
        drive(8'h12, 6, 1, 3);
        drive(8'h10, 6, 2, 3);
        drive(8'h10, 6, 3, 3);
        drive(8'h10, 6, 4, 3);
        tick();
        tick();
        drive(8'h02, 6, 2, 3);
        drive(8'h02, 6, 3, 3);
        drive(8'h02, 6, 4, 3);
        wait_words("hold_count", 10);
        check_pkt("hold_p1", 0, 1, 6, 3, 0);
        check_pkt("hold_p4", 5, 4, 6, 3, 1);
        gap_chk("hold_gap", 5);

        // Fill port 2, then reset after its third output word.
        got.delete();
        out_rdy = 1'b0;
        for (int w = 0; w < 8; w++) drive(8'h04, 7, w, 6);
        chk("full_in_rdy", in_rdy, 8'hFB);
        out_rdy = 1'b1;
        begin : wait_mid
            int k;
            k = 0;
            while (got.size() < 3 && k < 50) begin
                tick();
                k++;
            end
        end
        chk("mid_count", got.size(), 3);
        reset_n = 1'b0;
        tick();
        chk("mid_out_wr", out_wr, 0);
        chk("mid_out_data", out_data, 0);
        chk("mid_out_ctrl", out_ctrl, 0);
        reset_n = 1'b1;
        tick();
        chk("mid_in_rdy", in_rdy, 8'hFF);
        repeat (10) tick();
        chk("mid_no_tail", got.size(), 3);
        for (int w = 0; w < 3; w++) begin
            logic [71:0] obs;
            obs = {72{1'bx}};
            if (w < got.size()) obs = {got[w].c, got[w].d};
            chk($sformatf("mid_w%0d", w), obs, exp_word(2, 7, w, 6));
        end
        got.delete();
        for (int w = 0; w < 4; w++) drive(8'h04, 8, w, 2);
        wait_words("post_count", 4);
        check_pkt("post", 0, 2, 8, 2, 1);

        $display("%0d/%0d checks passed", passed, passed + fails);
        $finish;
    end
endmodule

// File: doc/input_arbiter_rr.md
INPUT_ARBITER_RR -- requirements
Module: input_arbiter_rr

Interface
- REQ-001: Parameter DATA_WIDTH, default 64, datapath word width in bits.
- REQ-002: Parameter CTRL_WIDTH, default DATA_WIDTH/8, control bits per word.
- REQ-003: Parameter NUM_INPUT_QUEUES, default 8, number of input ports; QW = log2(NUM_INPUT_QUEUES).
- REQ-004: clk  input  1  single clock; all logic is on the rising edge.
- REQ-005: reset_n  input  1  synchronous, active-low reset.
- REQ-006: in_data  input  NUM_INPUT_QUEUES*DATA_WIDTH  per-port data; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- REQ-007: in_ctrl  input  NUM_INPUT_QUEUES*CTRL_WIDTH  per-port ctrl; port i occupies slice [i*CTRL_WIDTH +: CTRL_WIDTH].
- REQ-008: in_wr  input  NUM_INPUT_QUEUES  per-port write strobe.
- REQ-009: in_rdy  output  NUM_INPUT_QUEUES  per-port ready; in_rdy[i] = !nearly_full of input FIFO i.
- REQ-010: out_data  output  DATA_WIDTH  merged data stream.
- REQ-011: out_ctrl  output  CTRL_WIDTH  merged ctrl stream.
- REQ-012: out_wr  output  1  word valid on out_data/out_ctrl.
- REQ-013: out_rdy  input  1  downstream can accept words.

Function
- REQ-014: Each port SHALL have one small_fifo of width CTRL_WIDTH+DATA_WIDTH and MAX_DEPTH_BITS 3; in_wr[i] writes {ctrl,data} into FIFO i.
- REQ-015: Packet framing SHALL be as follows: module-header words have ctrl != 0; payload words have ctrl == 0; the first ctrl != 0 word after at least one ctrl == 0 word is EOP.
- REQ-016: The FSM SHALL have states SELECT, HDR and PAYLOAD, with a QW-bit grant register cur_q and a QW-bit round-robin pointer rr_ptr.
- REQ-017: In SELECT, the FSM SHALL grant the first non-empty FIFO searching from rr_ptr upward with wrap-around; it SHALL set cur_q and go to HDR; with no FIFO non-empty it SHALL stay in SELECT.
- REQ-018: SELECT SHALL issue no FIFO read; the first read of a packet occurs in the cycle after the grant.
- REQ-019: In HDR and PAYLOAD, rd_en[cur_q] SHALL equal !empty[cur_q] && out_rdy && !eop_pending; all other rd_en bits SHALL be 0.
- REQ-020: out_wr, out_data and out_ctrl SHALL be registered; a word read in cycle N SHALL appear with out_wr=1 in cycle N+1, so latency is 1 cycle from rd_en.
- REQ-021: out_wr SHALL be 0 in any cycle following a cycle with no read.
- REQ-022: HDR SHALL move to PAYLOAD when the word read has ctrl == 0.
- REQ-023: In PAYLOAD, reading a word with ctrl != 0 SHALL set eop_pending; the next cycle SHALL clear it, set rr_ptr = cur_q+1 (mod NUM_INPUT_QUEUES) and return to SELECT.
- REQ-024: Minimum inter-packet gap at the output SHALL be 1 idle cycle.
- REQ-025: A header word with ctrl == `IO_QUEUE_STAGE_NUM SHALL be output with bits [`IOQ_SRC_PORT_POS+15:`IOQ_SRC_PORT_POS] replaced by cur_q, zero-extended to 16 bits; all other words SHALL pass unmodified.
- REQ-026: An empty granted FIFO mid-packet SHALL stall the packet without releasing the grant; the arbiter SHALL NOT interleave words of different packets.
- REQ-027: out_rdy low SHALL stall reads; words already read SHALL still be output the next cycle.
- REQ-028: in_wr[i] with FIFO i full SHALL be a producer protocol violation; the block need not preserve data in that case.
- REQ-029: The block SHALL have no register interface and no packet length limit other than the framing in REQ-015.

Reset
- REQ-030: While reset_n == 0 at a rising edge, the block SHALL clear out_wr, out_data, out_ctrl, rr_ptr, cur_q and eop_pending to 0, set the state to SELECT, and reset all FIFOs to empty.
- REQ-031: After reset, in_rdy SHALL be all ones on the first cycle with reset_n == 1.
- REQ-032: Reset mid-packet SHALL discard the partial packet; no tail words SHALL be output after reset.

Verification
- REQ-033: Single packet on port 3 (IOQ header ctrl=0xFF, 4 words ctrl=0x00, EOP ctrl=0x01), out_rdy=1 -> 6 consecutive out_wr words; the header's src field reads 3; the packet ends with ctrl=0x01.
- REQ-034: Ports 0, 2 and 7 each hold one packet, rr_ptr=0 -> output order 0, 2, 7, with each packet contiguous and at least 1 idle cycle between packets.
- REQ-035: Port 5 sends back-to-back packets while port 6 holds one -> order 5, 6, 5; port 6 is not starved.
- REQ-036: out_rdy toggles 1/0 every cycle during an 8-word packet -> all 8 words are output in order with no duplicates or losses, and out_wr is never set when no read occurred the prior cycle.
- REQ-037: Port 1's producer pauses 5 cycles mid-payload while port 4 is non-empty -> port 4 words do not appear until port 1's EOP has been output.
- REQ-038: reset_n pulled low for 1 cycle after the third word of a packet -> out_wr=0 the next cycle, no further words of that packet appear, and a new packet afterwards passes intact.
